// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the 16-bit five-stage pipeline
// hazard logic.
//   pipe_tag_t      destination tag carried for one in-flight instruction
//   FWD_RF          forwarding select value meaning "read the register file"
//   FWD_STAGE_BASE  select value of tag entry 0 (entry k -> k + FWD_STAGE_BASE)
//   NOP_INSTR       instruction word loaded into ID/EX when a bubble is issued
//   BUBBLE_TAG      tag that a bubble leaves in the tag pipeline
package pipe_pkg;

  // Tag address storage is sized for the widest register file supported.
  // Narrower files are zero-extended into it.
  localparam int unsigned MAX_REG_AW = 8;

  typedef logic [MAX_REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      we;
    logic      is_load;
    reg_addr_t addr;
  } pipe_tag_t;

  localparam int unsigned FWD_RF         = 0;
  localparam int unsigned FWD_STAGE_BASE = 1;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam pipe_tag_t   BUBBLE_TAG = '0;

endpackage

// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: PIPE_DEPTH-entry shift register of destination tags for
// the instructions in flight after ID (entry 0 = EX, entry PIPE_DEPTH-1 = WB).
//   clk     clock
//   rst     asynchronous active-high clear; every entry becomes invalid
//   tag_i   tag of the instruction currently in ID
//   kill_i  1 = ID is not advancing into EX, insert a bubble tag instead
//   tags_o  current contents of all entries
module hazard_tag_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  pipe_tag_t                  tag_i,
  input  logic                       kill_i,
  output pipe_tag_t [PIPE_DEPTH-1:0] tags_o
);

  pipe_tag_t [PIPE_DEPTH-1:0] tags_q;
  pipe_tag_t [PIPE_DEPTH-1:0] tags_d;

  always_comb begin
    tags_d = {tags_q[PIPE_DEPTH-2:0], (kill_i ? BUBBLE_TAG : tag_i)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags_q <= '0;
    end else begin
      tags_q <= tags_d;
    end
  end

  assign tags_o = tags_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and forwarding control beside the ID
// stage. Tracks destination tags of in-flight instructions and produces
// stall / bubble / flush and per-source forwarding selects every cycle.
//   clk, rst                      clock, asynchronous active-high reset
//   id_valid                      ID holds a real instruction
//   id_src{0,1}_addr/_use         source register addresses and read enables
//   id_dst_addr, id_dst_we        destination register and write enable
//   id_is_load                    result appears in MEM rather than EX
//   br_taken                      branch/jump resolved taken in EX
//   stall                         hold PC and IF/ID
//   bubble                        load a NOP into ID/EX
//   flush                         clear IF/ID
//   fwd_sel{0,1}                  0 = register file, k = result of tag entry k-1
//   stall_cnt, flush_cnt          saturating event counters
// REG_AW must not exceed pipe_pkg::MAX_REG_AW.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned FSW       = $clog2(PIPE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src0_addr,
  input  logic [REG_AW-1:0] id_src1_addr,
  input  logic              id_src0_use,
  input  logic              id_src1_use,
  input  logic [REG_AW-1:0] id_dst_addr,
  input  logic              id_dst_we,
  input  logic              id_is_load,
  input  logic              br_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [FSW-1:0]    fwd_sel0,
  output logic [FSW-1:0]    fwd_sel1,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // WB is excluded from hazards: the register file writes in the first
  // half-cycle, so ID reads the new value directly.
  localparam logic [PIPE_DEPTH-1:0] FWD_WINDOW = {1'b0, {(PIPE_DEPTH-1){1'b1}}};
  // Only a load sitting in EX is too late to forward from.
  localparam logic [PIPE_DEPTH-1:0] EX_SLOT    = {{(PIPE_DEPTH-1){1'b0}}, 1'b1};

  pipe_tag_t                  id_tag;
  pipe_tag_t [PIPE_DEPTH-1:0] tags;

  logic [PIPE_DEPTH-1:0] hit0, hit1;
  logic [PIPE_DEPTH-1:0] haz0, haz1;
  logic [PIPE_DEPTH-1:0] ld_vec;
  logic                  raw_stall;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic src_match(input pipe_tag_t         t,
                                     input logic [REG_AW-1:0] a,
                                     input logic              src_use);
    reg_addr_t a_ext;
    a_ext              = '0;
    a_ext[REG_AW-1:0]  = a;
    return src_use & t.valid & t.we & (t.addr == a_ext) &
           ((a != '0) | (ZERO_REG == 0));
  endfunction

  // Lowest index wins: entry 0 holds the youngest, most recent value.
  function automatic logic [FSW-1:0] youngest(input logic [PIPE_DEPTH-1:0] haz);
    logic [FSW-1:0] sel;
    logic           found;
    sel   = FSW'(FWD_RF);
    found = 1'b0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      if (haz[k] && !found) begin
        sel   = FSW'(k + FWD_STAGE_BASE);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    id_tag                      = BUBBLE_TAG;
    id_tag.valid                = id_valid;
    id_tag.we                   = id_dst_we;
    id_tag.is_load              = id_is_load;
    id_tag.addr[REG_AW-1:0]     = id_dst_addr;
  end

  hazard_tag_pipe #(
    .PIPE_DEPTH(PIPE_DEPTH)
  ) u_tags (
    .clk    (clk),
    .rst    (rst),
    .tag_i  (id_tag),
    .kill_i (bubble),
    .tags_o (tags)
  );

  always_comb begin
    hit0   = '0;
    hit1   = '0;
    ld_vec = '0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      hit0[k]   = src_match(tags[k], id_src0_addr, id_src0_use);
      hit1[k]   = src_match(tags[k], id_src1_addr, id_src1_use);
      ld_vec[k] = tags[k].is_load;
    end
    haz0 = hit0 & FWD_WINDOW;
    haz1 = hit1 & FWD_WINDOW;
  end

  always_comb begin
    raw_stall = 1'b0;
    fwd_sel0  = FSW'(FWD_RF);
    fwd_sel1  = FSW'(FWD_RF);
    if (FWD_EN != 0) begin
      raw_stall = |((haz0 | haz1) & ld_vec & EX_SLOT);
      fwd_sel0  = youngest(haz0);
      fwd_sel1  = youngest(haz1);
    end else begin
      raw_stall = |(haz0 | haz1);
    end
  end

  // Flush overrides stall; an empty ID slot never stalls.
  assign flush  = br_taken & ~rst;
  assign stall  = raw_stall & id_valid & ~flush;
  assign bubble = stall | flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int PD = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, id_src0_use, id_src1_use, id_dst_we, id_is_load, br_taken;
  logic [3:0] id_src0_addr, id_src1_addr, id_dst_addr;

  logic        f_stall, f_bubble, f_flush;
  logic [1:0]  f_sel0, f_sel1;
  logic [15:0] f_stall_cnt, f_flush_cnt;
  logic        n_stall, n_bubble, n_flush;
  logic [1:0]  n_sel0, n_sel1;
  logic [3:0]  n_stall_cnt, n_flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(4), .PIPE_DEPTH(PD), .FWD_EN(1), .ZERO_REG(1), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
    .id_src0_use(id_src0_use), .id_src1_use(id_src1_use),
    .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we), .id_is_load(id_is_load),
    .br_taken(br_taken), .stall(f_stall), .bubble(f_bubble), .flush(f_flush),
    .fwd_sel0(f_sel0), .fwd_sel1(f_sel1), .stall_cnt(f_stall_cnt), .flush_cnt(f_flush_cnt));

  pipe_hazard_ctrl #(.REG_AW(4), .PIPE_DEPTH(PD), .FWD_EN(0), .ZERO_REG(1), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src0_addr(id_src0_addr), .id_src1_addr(id_src1_addr),
    .id_src0_use(id_src0_use), .id_src1_use(id_src1_use),
    .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we), .id_is_load(id_is_load),
    .br_taken(br_taken), .stall(n_stall), .bubble(n_bubble), .flush(n_flush),
    .fwd_sel0(n_sel0), .fwd_sel1(n_sel1), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int a0, input bit u0, input int a1, input bit u1,
                       input int d, input bit we, input bit ld, input bit br);
    id_valid     = v;
    id_src0_addr = 4'(a0);
    id_src0_use  = u0;
    id_src1_addr = 4'(a1);
    id_src1_use  = u1;
    id_dst_addr  = 4'(d);
    id_dst_we    = we;
    id_is_load   = ld;
    br_taken     = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table (FWD_EN=1 instance) ----------------
  typedef struct {
    bit v; int a0; bit u0; int a1; bit u1; int d; bit we; bit ld; bit br;
    bit st; bit fl; int sel0; int sel1;
  } vec_t;

  vec_t tbl[16];

  // ---------------- reference model: list of in-flight writers ----------------
  // Each accepted writer is remembered with the cycle it left ID; its distance
  // from ID (0 = EX) is the number of cycles elapsed since then, minus one.
  typedef struct { int inst; int cyc; int addr; bit ld; } rec_t;
  rec_t inflight[$];
  int   mcyc = 0;
  int   mst[2];
  int   mfl[2];

  function automatic void find(input int inst, input int addr, input bit src_use,
                               output int k, output bit ld);
    k  = -1;
    ld = 1'b0;
    if (!src_use || addr == 0) return;
    foreach (inflight[j]) begin
      int age;
      age = mcyc - inflight[j].cyc - 1;
      if (inflight[j].inst == inst && inflight[j].addr == addr && age < PD - 1 &&
          (k < 0 || age < k)) begin
        k  = age;
        ld = inflight[j].ld;
      end
    end
  endfunction

  task automatic model_check(input int inst);
    int k0, k1, es0, es1, cmax;
    bit l0, l1, est, efl;
    string p;
    logic [31:0] a_st, a_bb, a_fl, a_s0, a_s1, a_sc, a_fc;
    p    = (inst == 0) ? "rand.f" : "rand.n";
    cmax = (inst == 0) ? 65535 : 15;
    est = 0; efl = 0; es0 = 0; es1 = 0;
    if (!rst) begin
      find(inst, int'(id_src0_addr), id_src0_use, k0, l0);
      find(inst, int'(id_src1_addr), id_src1_use, k1, l1);
      efl = br_taken;
      if (inst == 0) begin
        es0 = (k0 < 0) ? 0 : k0 + 1;
        es1 = (k1 < 0) ? 0 : k1 + 1;
        est = !efl && id_valid && ((k0 == 0 && l0) || (k1 == 0 && l1));
      end else begin
        est = !efl && id_valid && (k0 >= 0 || k1 >= 0);
      end
    end
    if (inst == 0) begin
      a_st = 32'(f_stall); a_bb = 32'(f_bubble); a_fl = 32'(f_flush);
      a_s0 = 32'(f_sel0);  a_s1 = 32'(f_sel1);
      a_sc = 32'(f_stall_cnt); a_fc = 32'(f_flush_cnt);
    end else begin
      a_st = 32'(n_stall); a_bb = 32'(n_bubble); a_fl = 32'(n_flush);
      a_s0 = 32'(n_sel0);  a_s1 = 32'(n_sel1);
      a_sc = 32'(n_stall_cnt); a_fc = 32'(n_flush_cnt);
    end
    chk({p, ".stall"},     a_st, 32'(est));
    chk({p, ".bubble"},    a_bb, 32'(est | efl));
    chk({p, ".flush"},     a_fl, 32'(efl));
    chk({p, ".fwd_sel0"},  a_s0, 32'(es0));
    chk({p, ".fwd_sel1"},  a_s1, 32'(es1));
    chk({p, ".stall_cnt"}, a_sc, 32'(mst[inst]));
    chk({p, ".flush_cnt"}, a_fc, 32'(mfl[inst]));
    if (!rst) begin
      if (est && mst[inst] < cmax) mst[inst]++;
      if (efl && mfl[inst] < cmax) mfl[inst]++;
      if (id_valid && id_dst_we && !est && !efl)
        inflight.push_back('{inst, mcyc, int'(id_dst_addr), id_is_load});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    //        v  a0 u0 a1 u1  d we ld br   st fl s0 s1
    tbl = '{
      '{1, 2, 1, 3, 1, 1, 1, 0, 0,   0, 0, 0, 0},  // ADD R1
      '{1, 1, 1, 1, 1, 2, 1, 0, 0,   0, 0, 1, 1},  // ADD R2,R1,R1: EX forward
      '{1, 1, 1, 2, 1, 6, 1, 0, 0,   0, 0, 2, 1},  // R1 now in MEM
      '{1, 1, 1, 6, 1, 7, 1, 0, 0,   0, 0, 0, 1},  // R1 in WB: register file
      '{1, 0, 1, 0, 0, 3, 1, 1, 0,   0, 0, 0, 0},  // LW R3
      '{1, 3, 1, 7, 1, 8, 1, 0, 0,   1, 0, 1, 2},  // load-use: stall
      '{1, 3, 1, 7, 1, 8, 1, 0, 0,   0, 0, 2, 0},  // held: forward from MEM
      '{1, 8, 1, 0, 0, 9, 1, 1, 1,   0, 1, 1, 0},  // taken branch kills LW R9
      '{1, 8, 1, 0, 0,10, 1, 1, 0,   0, 0, 2, 0},  // LW R10
      '{1,10, 1, 0, 0,11, 1, 0, 1,   0, 1, 1, 0},  // branch during load-use
      '{1,11, 1,10, 1,12, 1, 0, 0,   0, 0, 0, 2},  // killed R11 not forwarded
      '{1,12, 1, 0, 0, 0, 1, 0, 0,   0, 0, 1, 0},  // writer of R0
      '{1, 0, 1, 0, 1,13, 1, 1, 0,   0, 0, 0, 0},  // reader of R0
      '{0,13, 1, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0},  // empty ID never stalls
      '{1, 0, 0,13, 1, 4, 0, 0, 0,   0, 0, 0, 2},  // non-writer
      '{1, 4, 1,13, 1, 5, 1, 0, 0,   0, 0, 0, 0}   // we=0 producer never matches
    };

    // Reset with garbage inputs and a taken branch.
    idle();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 1), $urandom_range(0, 15), 1, $urandom_range(0, 15), 1,
            $urandom_range(0, 15), 1, $urandom_range(0, 1), 1);
      #1;
      chk("rst.f.stall",     32'(f_stall),     0);
      chk("rst.f.bubble",    32'(f_bubble),    0);
      chk("rst.f.flush",     32'(f_flush),     0);
      chk("rst.f.fwd_sel0",  32'(f_sel0),      0);
      chk("rst.f.fwd_sel1",  32'(f_sel1),      0);
      chk("rst.f.stall_cnt", 32'(f_stall_cnt), 0);
      chk("rst.f.flush_cnt", 32'(f_flush_cnt), 0);
      chk("rst.n.stall",     32'(n_stall),     0);
      chk("rst.n.flush",     32'(n_flush),     0);
      chk("rst.n.stall_cnt", 32'(n_stall_cnt), 0);
      chk("rst.n.flush_cnt", 32'(n_flush_cnt), 0);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a0, tbl[i].u0, tbl[i].a1, tbl[i].u1,
            tbl[i].d, tbl[i].we, tbl[i].ld, tbl[i].br);
      #1;
      chk($sformatf("tbl%0d.stall", i),    32'(f_stall),  32'(tbl[i].st));
      chk($sformatf("tbl%0d.flush", i),    32'(f_flush),  32'(tbl[i].fl));
      chk($sformatf("tbl%0d.bubble", i),   32'(f_bubble), 32'(tbl[i].st | tbl[i].fl));
      chk($sformatf("tbl%0d.fwd_sel0", i), 32'(f_sel0),   32'(tbl[i].sel0));
      chk($sformatf("tbl%0d.fwd_sel1", i), 32'(f_sel1),   32'(tbl[i].sel1));
    end
    @(negedge clk);
    idle();
    #1;
    chk("tbl.stall_cnt", 32'(f_stall_cnt), 1);
    chk("tbl.flush_cnt", 32'(f_flush_cnt), 2);

    // Interlock without forwarding: ADD R4, then a reader of R4 held in ID.
    do_reset();
    @(negedge clk);
    drive(1, 1, 1, 2, 1, 4, 1, 0, 0);
    #1;
    chk("nofwd.c0.stall", 32'(n_stall), 0);
    @(negedge clk);
    drive(1, 4, 1, 4, 1, 5, 1, 0, 0);
    #1;
    chk("nofwd.c1.stall",    32'(n_stall), 1);
    chk("nofwd.c1.fwd_sel0", 32'(n_sel0),  0);
    chk("nofwd.c1.fwd_sel1", 32'(n_sel1),  0);
    chk("alu.c1.stall",      32'(f_stall), 0);
    chk("alu.c1.fwd_sel0",   32'(f_sel0),  1);
    @(negedge clk);
    #1;
    chk("nofwd.c2.stall",    32'(n_stall), 1);
    chk("nofwd.c2.fwd_sel0", 32'(n_sel0),  0);
    @(negedge clk);
    #1;
    chk("nofwd.c3.stall",    32'(n_stall), 0);
    chk("nofwd.c3.fwd_sel0", 32'(n_sel0),  0);
    @(negedge clk);
    idle();
    #1;
    chk("nofwd.stall_cnt", 32'(n_stall_cnt), 2);

    // Saturation: dependent ALU chain on the 4-bit-counter interlock instance.
    do_reset();
    stalls = 0;
    for (int c = 0; c < 60 && stalls < 20; c++) begin
      @(negedge clk);
      drive(1, 5, 1, 5, 1, 5, 1, 0, 0);
      #1;
      if (n_stall) stalls++;
    end
    @(negedge clk);
    idle();
    #1;
    chk("sat.stall_cycles",  32'(stalls),      20);
    chk("sat.n.stall_cnt",   32'(n_stall_cnt), 15);
    chk("sat.f.stall_cnt",   32'(f_stall_cnt), 0);

    // Randomised traffic against the reference model, with occasional resets.
    do_reset();
    inflight.delete();
    mst = '{0, 0};
    mfl = '{0, 0};
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0);
      #1;
      if (rst) begin
        inflight.delete();
        mst = '{0, 0};
        mfl = '{0, 0};
      end
      model_check(0);
      model_check(1);
      mcyc++;
      while (inflight.size() > 0 && mcyc - inflight[0].cyc - 1 >= PD) void'(inflight.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
